// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - DEPTH-entry circular pipeline FIFO with valid/ready on both sides.
// Define PIPE_FIFO_BYPASS_EN for zero-latency fall-through when the FIFO is empty.
module pipe_fifo #(
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_SIZE-1:0]   data_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic                   flush,
   output logic [DATA_SIZE-1:0]   data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 wr_en;
   logic                 rd_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign ready_o = !full;
   assign count_o = count;

`ifdef PIPE_FIFO_BYPASS_EN
   // An empty FIFO presents the incoming entry directly; if it is taken
   // the same cycle it never touches storage.
   assign valid_o = !flush && (!empty || valid_i);
   assign data_o  = !valid_o ? '0 : (empty ? data_i : mem[rd_ptr]);
   assign push    = valid_i && ready_o && !flush;
   assign pop     = valid_o && ready_i && !flush;
   assign wr_en   = push && !(empty && pop);
   assign rd_en   = pop && !empty;
`else
   assign valid_o = !empty && !flush;
   assign data_o  = valid_o ? mem[rd_ptr] : '0;
   assign push    = valid_i && ready_o && !flush;
   assign pop     = valid_o && ready_i && !flush;
   assign wr_en   = push;
   assign rd_en   = pop;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Upstream must hold an offered entry until it is accepted.
   a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_i && !ready_o && !flush) |=> (valid_i || flush));

   a_depth_pow2: assert property (@(posedge clk) ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2));

endmodule

// File: tb/tb_pipe_fifo.sv
// tb/tb_pipe_fifo.sv - table-driven self-checking bench for pipe_fifo.
module tb_pipe_fifo;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic        flush;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic [2:0]  count_o;

   int errors;
   int checks;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        f;
      logic        ev;
      logic [31:0] ed;
      logic [2:0]  ec;
      logic        er;
   } vec_t;

   vec_t vecs[$];

   pipe_fifo #(.DATA_SIZE(32), .DEPTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .flush   (flush),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .count_o (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                            input logic [2:0] ec, input logic er);
      check({tag, " valid_o"}, 32'(valid_o), 32'(ev));
      check({tag, " data_o"},  data_o, ed);
      check({tag, " count_o"}, 32'(count_o), 32'(ec));
      check({tag, " ready_o"}, 32'(ready_o), 32'(er));
   endtask

   task automatic add(input logic v, input logic [31:0] d, input logic r, input logic f,
                      input logic ev, input logic [31:0] ed, input logic [2:0] ec, input logic er);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.f = f;
      t.ev = ev; t.ed = ed; t.ec = ec; t.er = er;
      vecs.push_back(t);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      valid_i = 1'b0;
      data_i  = '0;
      ready_i = 1'b0;
      flush   = 1'b0;

      // fill to full with downstream stalled
      add(1, 32'h11, 0, 0, 0, 32'h00, 3'd0, 1);
      add(1, 32'h22, 0, 0, 1, 32'h11, 3'd1, 1);
      add(1, 32'h33, 0, 0, 1, 32'h11, 3'd2, 1);
      add(1, 32'h44, 0, 0, 1, 32'h11, 3'd3, 1);
      add(0, 32'h00, 0, 0, 1, 32'h11, 3'd4, 0);
      // drain in order
      add(0, 32'h00, 1, 0, 1, 32'h11, 3'd4, 0);
      add(0, 32'h00, 1, 0, 1, 32'h22, 3'd3, 1);
      add(0, 32'h00, 1, 0, 1, 32'h33, 3'd2, 1);
      add(0, 32'h00, 1, 0, 1, 32'h44, 3'd1, 1);
      add(0, 32'h00, 0, 0, 0, 32'h00, 3'd0, 1);
      // streaming 1..10, first cycle is empty so no pop
      add(1, 32'd1, 1, 0, 0, 32'd0, 3'd0, 1);
      for (int k = 2; k <= 10; k++) begin
         add(1, 32'(k), 1, 0, 1, 32'(k - 1), 3'd1, 1);
      end
      add(0, 32'h00, 1, 0, 1, 32'd10, 3'd1, 1);
      add(0, 32'h00, 0, 0, 0, 32'h00, 3'd0, 1);
      // full with ready_i=1: pop only, offered entry held until accepted
      add(1, 32'hC1, 0, 0, 0, 32'h00, 3'd0, 1);
      add(1, 32'hC2, 0, 0, 1, 32'hC1, 3'd1, 1);
      add(1, 32'hC3, 0, 0, 1, 32'hC1, 3'd2, 1);
      add(1, 32'hC4, 0, 0, 1, 32'hC1, 3'd3, 1);
      add(1, 32'hC5, 1, 0, 1, 32'hC1, 3'd4, 0);
      add(1, 32'hC5, 1, 0, 1, 32'hC2, 3'd3, 1);
      add(0, 32'h00, 1, 0, 1, 32'hC3, 3'd3, 1);
      add(0, 32'h00, 1, 0, 1, 32'hC4, 3'd2, 1);
      add(0, 32'h00, 1, 0, 1, 32'hC5, 3'd1, 1);
      add(0, 32'h00, 0, 0, 0, 32'h00, 3'd0, 1);
      // flush at count 3 with push and pop requested
      add(1, 32'hA1, 0, 0, 0, 32'h00, 3'd0, 1);
      add(1, 32'hA2, 0, 0, 1, 32'hA1, 3'd1, 1);
      add(1, 32'hA3, 0, 0, 1, 32'hA1, 3'd2, 1);
      add(1, 32'hAA, 1, 1, 0, 32'h00, 3'd3, 1);
      add(0, 32'h00, 1, 0, 0, 32'h00, 3'd0, 1);
      add(1, 32'hBB, 0, 0, 0, 32'h00, 3'd0, 1);
      add(0, 32'h00, 1, 0, 1, 32'hBB, 3'd1, 1);
      add(0, 32'h00, 0, 0, 0, 32'h00, 3'd0, 1);

      #3;
      check_all("reset", 1'b0, 32'h0, 3'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         valid_i = vecs[i].v;
         data_i  = vecs[i].d;
         ready_i = vecs[i].r;
         flush   = vecs[i].f;
         @(negedge clk);
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].er);
         @(posedge clk);
         #1;
      end

      // asynchronous reset mid-cycle after a push
      valid_i = 1'b1; data_i = 32'h55; ready_i = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      #1;
      check("pre_reset count_o", 32'(count_o), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 1'b0, 32'h0, 3'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b1; data_i = 32'h66;
      @(posedge clk);
      #1;
      valid_i = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      check_all("after_reset", 1'b1, 32'h66, 3'd1, 1'b1);
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      @(negedge clk);
      check_all("after_reset_drain", 1'b0, 32'h0, 3'd0, 1'b1);
      @(posedge clk);
      #1;

      // empty FIFO, push and consume requested together
      valid_i = 1'b1; data_i = 32'h77; ready_i = 1'b1;
      @(negedge clk);
`ifdef PIPE_FIFO_BYPASS_EN
      check_all("bypass_same", 1'b1, 32'h77, 3'd0, 1'b1);
`else
      check_all("bypass_same", 1'b0, 32'h0, 3'd0, 1'b1);
`endif
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
`ifdef PIPE_FIFO_BYPASS_EN
      check_all("bypass_next", 1'b0, 32'h0, 3'd0, 1'b1);
`else
      check_all("bypass_next", 1'b1, 32'h77, 3'd1, 1'b1);
`endif
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      @(negedge clk);
      check_all("bypass_end", 1'b0, 32'h0, 3'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
